// File: rtl/pg_cfg_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pg_cfg_ctrl_pkg
// Shared rule-table geometry for the port-group configuration controller and
// the rule tables it writes.
//   RULE_AWIDTH   : width of a rule table address
//   RULE_PG_WIDTH : width of one rule-to-port-group entry
//   RULE_DEPTH    : number of implemented entries (addresses >= this are
//                   rejected by the controller)
//   rule_wr_t     : one table write (address + entry contents)
// ----------------------------------------------------------------------------
package pg_cfg_ctrl_pkg;

    localparam int RULE_AWIDTH   = 5;
    localparam int RULE_PG_WIDTH = 8;
    localparam int RULE_DEPTH    = 24;

    typedef struct packed {
        logic [RULE_AWIDTH-1:0]   addr;
        logic [RULE_PG_WIDTH-1:0] data;
    } rule_wr_t;

    // True when the address names an implemented table entry.
    function automatic logic rule_addr_ok(input logic [RULE_AWIDTH-1:0] addr);
        return int'(addr) < RULE_DEPTH;
    endfunction

endpackage

// File: rtl/pg_cfg_ctrl_if.sv
// ----------------------------------------------------------------------------
// pg_cfg_ctrl_if
// Host configuration beat channel into pg_cfg_ctrl.
//   cfg_valid : host has a beat on cfg_addr/cfg_data/cfg_last
//   cfg_ready : controller accepts the beat this cycle
//   cfg_addr  : target rule table entry
//   cfg_data  : entry contents
//   cfg_last  : final beat of a burst
// Handshake: a beat transfers on every rising clk edge where cfg_valid and
// cfg_ready are both 1. Once cfg_valid is raised the host holds it and the
// beat fields stable until that transfer; cfg_ready never depends on
// cfg_valid in the same cycle.
// Modports: master = host side, slave = controller side.
// ----------------------------------------------------------------------------
interface pg_cfg_ctrl_if;
    import pg_cfg_ctrl_pkg::*;

    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [RULE_AWIDTH-1:0]   cfg_addr;
    logic [RULE_PG_WIDTH-1:0] cfg_data;
    logic                     cfg_last;

    modport master (output cfg_valid, cfg_addr, cfg_data, cfg_last,
                    input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_addr, cfg_data, cfg_last,
                    output cfg_ready);

endinterface

// File: rtl/pg_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// pg_cfg_ctrl
// Applies host rule-table updates to a port group without disturbing packets
// in flight: admission is paused, the group is allowed to drain, the lookup
// pipeline is given DRAIN_CYCLES idle cycles, then the burst of table writes
// is accepted and admission resumes.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   cfg         : host config beat channel (pg_cfg_ctrl_if.slave)
//   pg_busy     : port group has a packet in flight
//   pg_pause    : blocks new metadata admission into the port group
//   wr_en/wr_addr/wr_data : registered table write port
//   wr_cnt      : accepted writes (wraps mod 2^32)
//   err_cnt     : beats dropped for out-of-range address (wraps mod 2^32)
//   err_timeout : sticky burst-abort flag
//   dbg_state   : current controller state, for observation only
//
// Parameters
//   DRAIN_CYCLES   : idle cycles between pg_busy low and the first write
//                    (0 behaves as 1)
//   TIMEOUT_CYCLES : max quiet cycles between beats inside a burst
//
// Build option: define PG_CFG_TIMEOUT_EN to end a stalled burst after
// TIMEOUT_CYCLES quiet cycles and flag err_timeout; without it the write
// phase waits for cfg_last indefinitely and err_timeout is 0.
// ----------------------------------------------------------------------------
module pg_cfg_ctrl
    import pg_cfg_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    pg_cfg_ctrl_if.slave             cfg,
    input  logic                     pg_busy,
    output logic                     pg_pause,
    output logic                     wr_en,
    output logic [RULE_AWIDTH-1:0]   wr_addr,
    output logic [RULE_PG_WIDTH-1:0] wr_data,
    output logic [31:0]              wr_cnt,
    output logic [31:0]              err_cnt,
    output logic                     err_timeout,
    output logic [2:0]               dbg_state
);

    localparam int D_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int DW    = $clog2(D_EFF + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PAUSE  = 3'd1,
        S_DRAIN  = 3'd2,
        S_WRITE  = 3'd3,
        S_RESUME = 3'd4
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [DW-1:0]  drain_cnt;
    logic           xfer;
    logic           gap_expire;
    rule_wr_t       wr_q;

    assign xfer      = cfg.cfg_valid & cfg.cfg_ready;
    assign dbg_state = state_q;
    assign wr_addr   = wr_q.addr;
    assign wr_data   = wr_q.data;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cfg.cfg_valid) state_d = S_PAUSE;
            S_PAUSE:  if (!pg_busy) state_d = S_DRAIN;
            // pg_busy is not looked at from here on: admission is blocked.
            S_DRAIN:  if (drain_cnt == '0) state_d = S_WRITE;
            S_WRITE: begin
                if (xfer && cfg.cfg_last) begin
                    state_d = S_RESUME;
                end else if (gap_expire) begin
                    state_d = S_RESUME;
                end
            end
            S_RESUME: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- state outputs ----------------
    always_comb begin
        pg_pause      = 1'b0;
        cfg.cfg_ready = 1'b0;
        case (state_q)
            S_PAUSE, S_DRAIN: pg_pause = 1'b1;
            S_WRITE: begin
                pg_pause      = 1'b1;
                cfg.cfg_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Drain counter: loaded as the group goes quiet, counts down to 0, and
    // the write phase opens in the cycle after it reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state_q == S_PAUSE && !pg_busy) begin
            drain_cnt <= DW'(D_EFF - 1);
        end else if (state_q == S_DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Write port and counters. A good beat shows up on wr_* in the cycle
    // after its transfer; wr_cnt moves in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_q    <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            wr_en <= xfer && rule_addr_ok(cfg.cfg_addr);
            if (xfer && rule_addr_ok(cfg.cfg_addr)) begin
                wr_q.addr <= cfg.cfg_addr;
                wr_q.data <= cfg.cfg_data;
                wr_cnt    <= wr_cnt + 32'd1;
            end
            if (xfer && !rule_addr_ok(cfg.cfg_addr)) begin
                err_cnt <= err_cnt + 32'd1;
            end
        end
    end

`ifdef PG_CFG_TIMEOUT_EN
    localparam int T_EFF = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int GW    = $clog2(T_EFF + 1);

    logic [GW-1:0] gap_cnt;

    // Quiet-cycle counter, only live in the write phase. The burst is cut
    // on the cycle that would bring the count to TIMEOUT_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state_q != S_WRITE || xfer) begin
            gap_cnt <= '0;
        end else if (!cfg.cfg_valid) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    assign gap_expire = (state_q == S_WRITE) && !cfg.cfg_valid &&
                        (gap_cnt == GW'(T_EFF - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (gap_expire) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign gap_expire  = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/pg_cfg_ctrl.md
PG_CFG_CTRL -- requirements
Module: pg_cfg_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 16, SHALL set idle cycles after pg_busy falls before the first table write; covers the rule lookup pipeline depth.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the max gap between cfg beats inside a burst (used only with PG_CFG_TIMEOUT_EN).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cfg_valid / cfg_ready  input / output  1 / 1  host config beat handshake.
REQ-006 cfg_addr  input  RULE_AWIDTH  target rule-to-port-group table entry.
REQ-007 cfg_data  input  RULE_PG_WIDTH  entry contents.
REQ-008 cfg_last  input  1  final beat of a burst.
REQ-009 pg_busy  input  1  port group has a packet in flight (metadata accepted, eop not yet drained).
REQ-010 pg_pause  output  1  blocks new metadata admission into the port group.
REQ-011 wr_en / wr_addr / wr_data  output  1 / RULE_AWIDTH / RULE_PG_WIDTH  table write port, fanned to every rule table.
REQ-012 wr_cnt / err_cnt  output  32 / 32  accepted writes / dropped beats.
REQ-013 err_timeout  output  1  sticky burst-abort flag.

Function
REQ-014 States: IDLE, PAUSE, DRAIN, WRITE, RESUME.
REQ-015 IDLE: pg_pause=0, cfg_ready=0; cfg_valid=1 -> PAUSE next cycle.
REQ-016 PAUSE: pg_pause=1; on pg_busy=0 -> DRAIN, drain counter loaded with DRAIN_CYCLES-1.
REQ-017 DRAIN: pg_pause=1; counter decrements each cycle; at 0 -> WRITE; DRAIN_CYCLES=0 treated as 1.
REQ-018 WRITE: pg_pause=1, cfg_ready=1; each beat with cfg_valid&cfg_ready is a transfer.
REQ-019 A transfer with cfg_addr < RULE_DEPTH SHALL produce wr_en=1 with registered wr_addr/wr_data exactly one cycle later, and wr_cnt+1 in that same cycle.
REQ-020 A transfer with cfg_addr >= RULE_DEPTH SHALL be consumed without wr_en and increment err_cnt.
REQ-021 A transfer with cfg_last=1 -> RESUME; cfg_ready=0 from the next cycle.
REQ-022 RESUME: one cycle, pg_pause=0, cfg_ready=0 -> IDLE; a new burst needs the full PAUSE/DRAIN sequence again.
REQ-023 wr_en SHALL never be asserted when pg_pause was 0 in the previous cycle.
REQ-024 pg_busy rising while in DRAIN or WRITE SHALL be ignored; admission is already blocked.
REQ-025 Counters SHALL wrap modulo 2^32 without saturation.

Reset
REQ-026 On rst: state=IDLE, pg_pause=0, cfg_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_cnt=0, err_cnt=0, err_timeout=0, all internal counters 0.
REQ-027 rst mid-burst SHALL abort at once; no write is issued for the beat in the reset cycle.

Configuration
REQ-028 With PG_CFG_TIMEOUT_EN defined: in WRITE, a gap counter counts cycles without cfg_valid and clears on every transfer; on reaching TIMEOUT_CYCLES the burst ends via RESUME, and err_timeout is set and stays set until rst.
REQ-029 Without PG_CFG_TIMEOUT_EN: no gap counter; WRITE waits indefinitely for cfg_last; err_timeout tied 0.

Structure
REQ-030 RULE_AWIDTH, RULE_PG_WIDTH and RULE_DEPTH SHALL come from the shared struct package; the FSM state enum SHALL be local to the module.
REQ-031 The design SHALL be a single module with no sub-modules; the output write registers are inline.

Verification
REQ-032 Burst of 3 beats, addr 5,6,7 (last on 7), data 0xA,0xB,0xC, pg_busy=0 -> wr_en pulses at cycles DRAIN_CYCLES+2..+4 with matching addr/data; wr_cnt=3; pg_pause falls after the last write.
REQ-033 pg_busy held 1 for 40 cycles after cfg_valid -> pg_pause=1 throughout, cfg_ready=0 until 40+DRAIN_CYCLES cycles, no wr_en before that point.
REQ-034 Beat with addr=RULE_DEPTH -> no wr_en, err_cnt=1; next beat addr 0 is written normally.
REQ-035 PG_CFG_TIMEOUT_EN with TIMEOUT_CYCLES=8: one beat, then cfg_valid=0 for 8 cycles -> RESUME, err_timeout=1, pg_pause=0.
REQ-036 rst asserted during WRITE with cfg_valid=1 -> outputs at reset values immediately, no wr_en; a following burst completes normally.
REQ-037 Back-to-back bursts (cfg_valid held after cfg_last) -> RESUME then IDLE each show pg_pause=0 for one cycle; second burst repeats the full drain sequence.
